// File: rtl/pc_fetch.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time and hands {pc, inst} to decode.
// Optional misaligned-fetch marker when FETCH_MISALIGN_EN is defined; otherwise PC loads are word-aligned.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  io_pc_sel,
  input  logic [31:0] io_pc_next,
  output logic [31:0] io_pc_pc4,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [31:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  output logic        io_if_valid,
  input  logic        io_if_ready,
  output logic [31:0] io_if_pc,
  output logic [31:0] io_if_inst,
  output logic        io_if_misalign
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_KILL
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic        r_req_valid;
  logic        r_if_valid;
`ifdef FETCH_MISALIGN_EN
  logic        r_if_misalign;
  logic [31:0] w_start_pc;
`endif

  logic        w_redirect;
  logic        w_fire;
  logic        w_load;
  logic        w_start;
  logic [31:0] w_next_pc;

  assign w_redirect = (io_pc_sel != 3'd0);
  assign w_fire     = r_if_valid && io_if_ready && !w_redirect;
  assign w_load     = w_redirect || w_fire;

`ifdef FETCH_MISALIGN_EN
  assign w_next_pc  = io_pc_next;
  assign w_start_pc = w_load ? w_next_pc : r_pc;
`else
  assign w_next_pc  = io_pc_next & 32'hFFFF_FFFC;
`endif

  // w_start: this cycle launches a fresh fetch of the (possibly just loaded) PC.
  always_comb begin
    // NOTE: default first so every path assigns w_start and no latch is inferred.
    w_start = 1'b0;
    case (r_state)
      S_IDLE:  w_start = 1'b1;
      S_REQ:   w_start = w_redirect && !io_imem_req_ready;
      S_WAIT:  w_start = w_redirect && io_imem_resp_valid;
      S_HOLD:  w_start = w_load;
      S_KILL:  w_start = io_imem_resp_valid;
      default: w_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_req_valid   <= 1'b0;
      r_if_valid    <= 1'b0;
      r_if_pc       <= 32'h0;
      r_if_inst     <= NOP_INST;
`ifdef FETCH_MISALIGN_EN
      r_if_misalign <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking throughout; later assignments in this block override earlier ones.
      if (w_load) r_pc <= w_next_pc;

      if (w_start) begin
        r_state     <= S_REQ;
        r_req_valid <= 1'b1;
        r_if_valid  <= 1'b0;
`ifdef FETCH_MISALIGN_EN
        r_if_misalign <= 1'b0;
        // A misaligned PC never reaches memory; decode gets a marker slot instead.
        if (w_start_pc[1:0] != 2'b00) begin
          r_state       <= S_HOLD;
          r_req_valid   <= 1'b0;
          r_if_valid    <= 1'b1;
          r_if_pc       <= w_start_pc;
          r_if_inst     <= NOP_INST;
          r_if_misalign <= 1'b1;
        end
`endif
      end else begin
        case (r_state)
          S_REQ: begin
            if (io_imem_req_ready) begin
              r_req_valid <= 1'b0;
              r_state     <= w_redirect ? S_KILL : S_WAIT;
            end
          end
          S_WAIT: begin
            if (w_redirect) begin
              r_state <= S_KILL;
            end else if (io_imem_resp_valid) begin
              r_state    <= S_HOLD;
              r_if_valid <= 1'b1;
              r_if_pc    <= r_pc;
              r_if_inst  <= io_imem_resp_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign io_pc_pc4         = r_pc + 32'd4;
  assign io_imem_req_valid = r_req_valid;
  assign io_imem_req_addr  = r_pc;
  // A redirect cycle never presents a valid slot, so fire and redirect are exclusive.
  assign io_if_valid       = r_if_valid && !w_redirect;
  assign io_if_pc          = r_if_pc;
  assign io_if_inst        = r_if_inst;
`ifdef FETCH_MISALIGN_EN
  assign io_if_misalign    = r_if_misalign;
`else
  assign io_if_misalign    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: cycle-by-cycle vector table plus hand sequences for reset and misalign.
// Inputs are driven on the falling edge and outputs sampled 1 ns later.
module tb_pc_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  io_pc_sel;
  logic [31:0] io_pc_next;
  logic [31:0] io_pc_pc4;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic        io_if_valid;
  logic        io_if_ready;
  logic [31:0] io_if_pc;
  logic [31:0] io_if_inst;
  logic        io_if_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .io_pc_sel          (io_pc_sel),
    .io_pc_next         (io_pc_next),
    .io_pc_pc4          (io_pc_pc4),
    .io_imem_req_valid  (io_imem_req_valid),
    .io_imem_req_ready  (io_imem_req_ready),
    .io_imem_req_addr   (io_imem_req_addr),
    .io_imem_resp_valid (io_imem_resp_valid),
    .io_imem_resp_data  (io_imem_resp_data),
    .io_if_valid        (io_if_valid),
    .io_if_ready        (io_if_ready),
    .io_if_pc           (io_if_pc),
    .io_if_inst         (io_if_inst),
    .io_if_misalign     (io_if_misalign)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] nxt;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        ifr;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] sel, input logic [31:0] nxt, input logic rdy,
                     input logic rv, input logic [31:0] rdata, input logic ifr,
                     input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                     input logic [31:0] e_ipc, input logic [31:0] e_inst);
    vec_t v;
    v.sel = sel; v.nxt = nxt; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.ifr = ifr;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_inst = e_inst;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [2:0] sel, input logic [31:0] nxt, input logic rdy,
                       input logic rv, input logic [31:0] rdata, input logic ifr);
    io_pc_sel          = sel;
    io_pc_next         = nxt;
    io_imem_req_ready  = rdy;
    io_imem_resp_valid = rv;
    io_imem_resp_data  = rdata;
    io_if_ready        = ifr;
  endtask

  initial begin
    //   sel  next          rdy rv rdata          ifr | e_rv e_addr        e_iv e_ipc         e_inst
    add(3'd0, 32'h4,        1, 0, 32'h0,          1,   0, 32'h0,          0, 32'h0,         32'h0);          // 0 IDLE
    add(3'd0, 32'h4,        1, 0, 32'h0,          1,   1, 32'h0,          0, 32'h0,         32'h0);          // 1 REQ 0 accepted
    add(3'd0, 32'h4,        1, 1, 32'hAAAA_0001,  1,   0, 32'h0,          0, 32'h0,         32'h0);          // 2 WAIT resp
    for (int i = 0; i < 5; i++)
      add(3'd0, 32'h4,      1, 0, 32'h0,          0,   0, 32'h0,          1, 32'h0,         32'hAAAA_0001);  // 3-7 HOLD stalled
    add(3'd0, 32'h4,        1, 0, 32'h0,          1,   0, 32'h0,          1, 32'h0,         32'hAAAA_0001);  // 8 fire
    add(3'd0, 32'h8,        1, 0, 32'h0,          1,   1, 32'h4,          0, 32'h0,         32'h0);          // 9 REQ 4 accepted
    add(3'd2, 32'h100,      1, 0, 32'h0,          1,   0, 32'h4,          0, 32'h0,         32'h0);          // 10 WAIT redirect
    add(3'd0, 32'h104,      1, 1, 32'hDEAD_0000,  1,   0, 32'h100,        0, 32'h0,         32'h0);          // 11 KILL drops resp
    add(3'd0, 32'h104,      0, 0, 32'h0,          1,   1, 32'h100,        0, 32'h0,         32'h0);          // 12 REQ not ready
    add(3'd0, 32'h104,      1, 0, 32'h0,          1,   1, 32'h100,        0, 32'h0,         32'h0);          // 13 REQ accepted
    add(3'd0, 32'h104,      1, 1, 32'h1111_0003,  1,   0, 32'h100,        0, 32'h0,         32'h0);          // 14 WAIT resp
    add(3'd0, 32'h104,      1, 0, 32'h0,          1,   0, 32'h100,        1, 32'h100,       32'h1111_0003);  // 15 fire
    add(3'd1, 32'h80,       1, 0, 32'h0,          1,   1, 32'h104,        0, 32'h0,         32'h0);          // 16 accept + redirect
    add(3'd0, 32'h84,       1, 0, 32'h0,          1,   0, 32'h80,         0, 32'h0,         32'h0);          // 17 KILL waiting
    add(3'd0, 32'h84,       1, 1, 32'h0BAD_0000,  1,   0, 32'h80,         0, 32'h0,         32'h0);          // 18 KILL drops resp
    add(3'd0, 32'h84,       1, 0, 32'h0,          1,   1, 32'h80,         0, 32'h0,         32'h0);          // 19 REQ 80 accepted
    add(3'd0, 32'h84,       1, 1, 32'h2222_0004,  1,   0, 32'h80,         0, 32'h0,         32'h0);          // 20 WAIT resp
    add(3'd0, 32'h84,       1, 0, 32'h0,          1,   0, 32'h80,         1, 32'h80,        32'h2222_0004);  // 21 fire
    add(3'd0, 32'h88,       0, 1, 32'h5555_0000,  1,   1, 32'h84,         0, 32'h0,         32'h0);          // 22 stray resp in REQ
    add(3'd3, 32'hFFFF_FFFC,0, 0, 32'h0,          1,   1, 32'h84,         0, 32'h0,         32'h0);          // 23 redirect in REQ
    add(3'd0, 32'h0,        1, 0, 32'h0,          1,   1, 32'hFFFF_FFFC,  0, 32'h0,         32'h0);          // 24 top of memory
    add(3'd0, 32'h0,        1, 1, 32'h3333_0005,  1,   0, 32'hFFFF_FFFC,  0, 32'h0,         32'h0);          // 25 WAIT resp
    add(3'd0, 32'h0,        1, 0, 32'h0,          1,   0, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC, 32'h3333_0005);  // 26 fire, wrap
    add(3'd0, 32'h4,        1, 0, 32'h0,          1,   1, 32'h0,          0, 32'h0,         32'h0);          // 27 REQ 0 accepted
    add(3'd0, 32'h4,        1, 1, 32'h4444_0006,  1,   0, 32'h0,          0, 32'h0,         32'h0);          // 28 WAIT resp
    add(3'd4, 32'h102,      1, 0, 32'h0,          1,   0, 32'h0,          0, 32'h0,         32'h0);          // 29 HOLD redirect

    reset_n = 1'b0;
    drive(3'd0, 32'h4, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("reset req_valid", {31'h0, io_imem_req_valid}, 32'h0);
    check("reset if_valid",  {31'h0, io_if_valid}, 32'h0);
    check("reset if_pc",     io_if_pc, 32'h0);
    check("reset if_inst",   io_if_inst, NOP);
    check("reset misalign",  {31'h0, io_if_misalign}, 32'h0);
    check("reset addr",      io_imem_req_addr, 32'h0);
    check("reset pc4",       io_pc_pc4, 32'h4);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].nxt, vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].ifr);
      #1;
      check($sformatf("v%0d req_valid", i), {31'h0, io_imem_req_valid}, {31'h0, vecs[i].e_rv});
      check($sformatf("v%0d addr", i), io_imem_req_addr, vecs[i].e_addr);
      check($sformatf("v%0d pc4", i), io_pc_pc4, vecs[i].e_addr + 32'd4);
      check($sformatf("v%0d if_valid", i), {31'h0, io_if_valid}, {31'h0, vecs[i].e_iv});
      check($sformatf("v%0d misalign", i), {31'h0, io_if_misalign}, 32'h0);
      if (vecs[i].e_iv) begin
        check($sformatf("v%0d if_pc", i), io_if_pc, vecs[i].e_ipc);
        check($sformatf("v%0d if_inst", i), io_if_inst, vecs[i].e_inst);
      end
      @(posedge clk);
      @(negedge clk);
    end

`ifdef FETCH_MISALIGN_EN
    // Redirect to 0x102 yields a marker slot with no memory request; it stays put while stalled.
    for (int c = 0; c < 2; c++) begin
      drive(3'd0, 32'h104, 1'b1, 1'(c), 32'h7777_0000, 1'b0);
      #1;
      check($sformatf("mis%0d if_valid", c), {31'h0, io_if_valid}, 32'h1);
      check($sformatf("mis%0d misalign", c), {31'h0, io_if_misalign}, 32'h1);
      check($sformatf("mis%0d if_pc", c), io_if_pc, 32'h102);
      check($sformatf("mis%0d if_inst", c), io_if_inst, NOP);
      check($sformatf("mis%0d req_valid", c), {31'h0, io_imem_req_valid}, 32'h0);
      @(posedge clk);
      @(negedge clk);
    end
    drive(3'd0, 32'h200, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    check("mis fire if_valid", {31'h0, io_if_valid}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    drive(3'd0, 32'h204, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    check("mis after req_valid", {31'h0, io_imem_req_valid}, 32'h1);
    check("mis after addr", io_imem_req_addr, 32'h200);
    check("mis after misalign", {31'h0, io_if_misalign}, 32'h0);
    check("mis after if_valid", {31'h0, io_if_valid}, 32'h0);
`else
    // Redirect to 0x102 is word-aligned down to 0x100 and fetched normally.
    drive(3'd0, 32'h104, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    check("align req_valid", {31'h0, io_imem_req_valid}, 32'h1);
    check("align addr", io_imem_req_addr, 32'h100);
    check("align pc4", io_pc_pc4, 32'h104);
    check("align if_valid", {31'h0, io_if_valid}, 32'h0);
    check("align misalign", {31'h0, io_if_misalign}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
